// File: rtl/dmem_miss_ctrl_if.sv
// Memory-stage request / data-memory bus bundle for the data-cache miss controller.
// The master side is the pipeline + cache, the slave side is dmem_miss_ctrl.
interface dmem_miss_ctrl_if;
    logic        req_valid;
    logic        wren;
    logic [31:0] addr;
    logic        hit;
    logic        stall;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic        fill_en;
    logic        countdone;
    logic [15:0] miss_count;

    modport master (
        output req_valid, wren, addr, hit,
        input  stall, mem_rd_en, mem_wr_en, mem_addr, fill_en, countdone, miss_count
    );

    modport slave (
        input  req_valid, wren, addr, hit,
        output stall, mem_rd_en, mem_wr_en, mem_addr, fill_en, countdone, miss_count
    );
endinterface

// File: rtl/dmem_miss_ctrl.sv
// Data-cache miss/store controller: stalls the pipeline while a line refill or word write runs.
// Define DMEM_WRITE_ALLOCATE_EN to refill the line on a store miss before writing the word.
module dmem_miss_ctrl #(
    parameter int MEM_LAT = 4   // memory latency in cycles, 1..15
) (
    input  logic             clk,
    input  logic             rst,
    dmem_miss_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REFILL,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] word_addr_reg, word_addr_next;
    logic        store_pend_reg, store_pend_next;
    logic [15:0] miss_count_reg, miss_count_next;

    logic        stall_c;
    logic        rd_c;
    logic        wr_c;
    logic        fill_c;
    logic        done_c;

    logic [31:0] line_addr;
    logic [31:0] word_addr;
    logic [15:0] miss_count_inc;

    assign line_addr      = {bus.addr[31:3], 3'b000};
    assign word_addr      = {bus.addr[31:2], 2'b00};
    assign miss_count_inc = (miss_count_reg == 16'hFFFF) ? miss_count_reg : miss_count_reg + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            mem_addr_reg   <= 32'd0;
            word_addr_reg  <= 32'd0;
            store_pend_reg <= 1'b0;
            miss_count_reg <= 16'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mem_addr_reg   <= mem_addr_next;
            word_addr_reg  <= word_addr_next;
            store_pend_reg <= store_pend_next;
            miss_count_reg <= miss_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        mem_addr_next   = mem_addr_reg;
        word_addr_next  = word_addr_reg;
        store_pend_next = store_pend_reg;
        miss_count_next = miss_count_reg;
        stall_c         = 1'b0;
        rd_c            = 1'b0;
        wr_c            = 1'b0;
        fill_c          = 1'b0;
        done_c          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = 4'd0;
                if (bus.req_valid && !bus.wren && !bus.hit) begin
                    stall_c         = 1'b1;
                    mem_addr_next   = line_addr;
                    store_pend_next = 1'b0;
                    miss_count_next = miss_count_inc;
                    state_next      = ST_REFILL;
                end else if (bus.req_valid && bus.wren) begin
                    stall_c        = 1'b1;
                    word_addr_next = word_addr;
                    if (bus.hit) begin
                        mem_addr_next   = word_addr;
                        store_pend_next = 1'b0;
                        state_next      = ST_WRITE;
                    end else begin
                        miss_count_next = miss_count_inc;
`ifdef DMEM_WRITE_ALLOCATE_EN
                        // Allocate: fetch the line first, write the word after the fill.
                        mem_addr_next   = line_addr;
                        store_pend_next = 1'b1;
                        state_next      = ST_REFILL;
`else
                        mem_addr_next   = word_addr;
                        store_pend_next = 1'b0;
                        state_next      = ST_WRITE;
`endif
                    end
                end
            end

            ST_REFILL: begin
                stall_c = 1'b1;
                rd_c    = 1'b1;
                if (cnt_reg == LAT_LAST) begin
                    cnt_next   = 4'd0;
                    state_next = ST_FILL;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_FILL: begin
                stall_c = 1'b1;
                fill_c  = 1'b1;
                if (store_pend_reg) begin
                    // Switch the bus from the line address to the pending store's word.
                    mem_addr_next = word_addr_reg;
                    state_next    = ST_WRITE;
                end else begin
                    state_next = ST_DONE;
                end
            end

            ST_WRITE: begin
                stall_c = 1'b1;
                wr_c    = 1'b1;
                if (cnt_reg == LAT_LAST) begin
                    cnt_next   = 4'd0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_DONE: begin
                done_c          = 1'b1;
                store_pend_next = 1'b0;
                state_next      = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Control outputs are forced low while reset is held, whatever the inputs do.
    assign bus.stall      = rst & stall_c;
    assign bus.mem_rd_en  = rst & rd_c;
    assign bus.mem_wr_en  = rst & wr_c;
    assign bus.fill_en    = rst & fill_c;
    assign bus.countdone  = rst & done_c;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.miss_count = miss_count_reg;

endmodule

// File: doc/dmem_miss_ctrl.md
DMEM_MISS_CTRL -- requirements
Module: dmem_miss_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 4, memory access latency in cycles, legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  memory-stage load/store present this cycle.
REQ-005 wren  input  1  1 = store, 0 = load; qualified by req_valid.
REQ-006 addr  input  32  memory-stage byte address (ALU result).
REQ-007 hit  input  1  cache tag-compare hit for addr, combinational from cache.
REQ-008 stall  output  1  freeze fetch/decode/execute/memory pipeline registers.
REQ-009 mem_rd_en  output  1  data memory line read active.
REQ-010 mem_wr_en  output  1  data memory word write active.
REQ-011 mem_addr  output  32  latched address to data memory.
REQ-012 fill_en  output  1  write the returned two-word line into the cache.
REQ-013 countdone  output  1  one-cycle pulse, access complete.
REQ-014 miss_count  output  16  saturating count of accepted misses.

Function
REQ-015 States: IDLE, REFILL, FILL, WRITE, DONE; one-hot or binary encoding.
REQ-016 IDLE, req_valid=1, wren=0, hit=1: no stall, stay IDLE, zero-latency load hit.
REQ-017 IDLE, req_valid=1, wren=0, hit=0: stall=1 combinationally same cycle, latch addr, next state REFILL.
REQ-018 IDLE, req_valid=1, wren=1: stall=1 same cycle, latch addr; next state WRITE on hit, or per REQ-032/033 on miss.
REQ-019 Latched address: REFILL uses {addr[31:3],3'b000}; WRITE uses {addr[31:2],2'b00}.
REQ-020 REFILL: exactly MEM_LAT cycles, mem_rd_en=1, 4-bit counter 0..MEM_LAT-1, then FILL.
REQ-021 FILL: exactly 1 cycle, fill_en=1, then WRITE if store pending, else DONE.
REQ-022 WRITE: exactly MEM_LAT cycles, mem_wr_en=1, counter 0..MEM_LAT-1, then DONE.
REQ-023 DONE: 1 cycle, countdone=1, stall=0, req_valid ignored, then IDLE.
REQ-024 stall=1 in REFILL, FILL, WRITE; stall=0 in DONE.
REQ-025 Load miss stall length = MEM_LAT+2 cycles; store hit = MEM_LAT+1 cycles.
REQ-026 req_valid, wren, hit, addr changes outside IDLE ignored; operation runs to completion.
REQ-027 miss_count increments by 1 on each IDLE acceptance with hit=0; holds at 16'hFFFF.
REQ-028 mem_addr holds last latched value in IDLE and DONE.

Reset
REQ-029 rst=0 at a rising edge: next state IDLE, counter 0, mem_addr 0, miss_count 0.
REQ-030 While in reset, stall, mem_rd_en, mem_wr_en, fill_en, countdone are 0 regardless of inputs.
REQ-031 Reset mid-operation abandons the access with no countdone pulse.

Configuration
REQ-032 DMEM_WRITE_ALLOCATE_EN defined: store miss goes REFILL -> FILL -> WRITE -> DONE, stall MEM_LAT*2+2 cycles.
REQ-033 DMEM_WRITE_ALLOCATE_EN undefined: store miss goes WRITE -> DONE, fill_en never asserted for stores, miss still counted.

Verification
REQ-034 MEM_LAT=4, load hit at T -> stall=0, state IDLE, countdone never asserted, miss_count unchanged.
REQ-035 MEM_LAT=4, load miss addr 0x0000_1014 at T -> stall T..T+5, mem_rd_en T+1..T+4, mem_addr 0x0000_1010, fill_en T+5, countdone T+6, miss_count=1.
REQ-036 MEM_LAT=4, store hit addr 0x0000_2006 -> mem_wr_en T+1..T+4, mem_addr 0x0000_2004, countdone T+5, no fill_en.
REQ-037 Store miss, both macro settings -> with macro: fill_en T+5, mem_wr_en T+6..T+9, countdone T+10; without: countdone T+5.
REQ-038 rst=0 at T+2 of a load miss -> IDLE at T+3, all outputs 0, no countdone, miss_count 0.
REQ-039 65540 back-to-back load misses -> miss_count saturates at 16'hFFFF.
